// File: rtl/shift_unit_arbiter_pkg.sv
// shift_unit_arbiter_pkg: shifter op codes and arbiter FSM state encodings
package shift_unit_arbiter_pkg;
  localparam logic [1:0] SHTOp_NOP = 2'b00;
  localparam logic [1:0] SHTOp_SLL = 2'b01;
  localparam logic [1:0] SHTOp_SRL = 2'b10;
  localparam logic [1:0] SHTOp_SRA = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/shift_unit_arbiter_shifter.sv
// shift_unit_arbiter_shifter: combinational barrel shifter (b, len, sht_op -> sht_out)
//   b       in  W  operand
//   len     in  5  shift amount
//   sht_op  in  2  NOP / SLL / SRL / SRA
//   sht_out out W  shifted operand
module shift_unit_arbiter_shifter
  import shift_unit_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] b,
  input  logic [4:0]   len,
  input  logic [1:0]   sht_op,
  output logic [W-1:0] sht_out
);
  // kept in its own signed net so the arithmetic shift is not turned logical by the mux
  logic signed [W-1:0] sra;
  assign sra = $signed(b) >>> len;
  always_comb
    sht_out = sht_op == SHTOp_SLL ? b << len :
              sht_op == SHTOp_SRL ? b >> len :
              sht_op == SHTOp_SRA ? sra      : b;
endmodule

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin sharing of one barrel shifter between two requesters
//   clk, rst_n                 clock, async active-low reset
//   a_req/a_data/a_len/a_op    requester A (ALU path)
//   b_req/b_data/b_len/b_op    requester B (load/store alignment)
//   a_gnt, b_gnt               owner of the shifter during SHIFT and DONE
//   a_done, b_done             one-cycle result-valid pulse to the winner
//   result                     registered shifter output, held until the next DONE
//   busy                       high outside IDLE
module shift_unit_arbiter
  import shift_unit_arbiter_pkg::*;
#(
  parameter int W      = 32,
  parameter bit PRIO_A = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req,
  input  logic [W-1:0] a_data,
  input  logic [4:0]   a_len,
  input  logic [1:0]   a_op,
  input  logic         b_req,
  input  logic [W-1:0] b_data,
  input  logic [4:0]   b_len,
  input  logic [1:0]   b_op,
  output logic         a_gnt,
  output logic         b_gnt,
  output logic         a_done,
  output logic         b_done,
  output logic [W-1:0] result,
  output logic         busy
);
  state_t       state;
  logic [W-1:0] op_data;
  logic [4:0]   op_len;
  logic [1:0]   op_code;
  logic         owner_a;
  logic         last_a;
  logic         pick_a;
  logic [W-1:0] sht_out;
  // A wins when alone, or on a tie when B was the previous winner
  assign pick_a = a_req & (~b_req | ~last_a);
  shift_unit_arbiter_shifter #(.W(W)) u_shifter (
    .b       (op_data),
    .len     (op_len),
    .sht_op  (op_code),
    .sht_out (sht_out)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_data <= '0;
      op_len  <= '0;
      op_code <= SHTOp_NOP;
      owner_a <= 1'b0;
      last_a  <= ~PRIO_A;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (a_req | b_req) begin
            op_data <= pick_a ? a_data : b_data;
            op_len  <= pick_a ? a_len  : b_len;
            op_code <= pick_a ? a_op   : b_op;
            owner_a <= pick_a;
            a_gnt   <= pick_a;
            b_gnt   <= ~pick_a;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        ST_SHIFT: begin
          result <= sht_out;
          a_done <= owner_a;
          b_done <= ~owner_a;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          a_done <= 1'b0;
          b_done <= 1'b0;
          a_gnt  <= 1'b0;
          b_gnt  <= 1'b0;
          busy   <= 1'b0;
          last_a <= owner_a;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed self-checking bench for shift_unit_arbiter
module tb_shift_unit_arbiter;
  import shift_unit_arbiter_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [31:0] a_data, b_data;
  logic [4:0]  a_len, b_len;
  logic [1:0]  a_op, b_op;
  logic        a_gnt, b_gnt, a_done, b_done, busy;
  logic [31:0] result;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  shift_unit_arbiter #(.W(32), .PRIO_A(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_data(a_data), .a_len(a_len), .a_op(a_op),
    .b_req(b_req), .b_data(b_data), .b_len(b_len), .b_op(b_op),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
    .result(result), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // one full grant for a single requester, starting in an IDLE cycle
  task automatic run_one(input string tag, input bit sel_a, input logic [31:0] d,
                         input logic [4:0] l, input logic [1:0] op, input logic [31:0] exp);
    if (sel_a) begin a_req = 1; a_data = d; a_len = l; a_op = op; end
    else begin b_req = 1; b_data = d; b_len = l; b_op = op; end
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    step;
    chk({tag, " shift a_gnt"}, {31'd0, a_gnt}, {31'd0, sel_a});
    chk({tag, " shift b_gnt"}, {31'd0, b_gnt}, {31'd0, ~sel_a});
    chk({tag, " shift busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " shift dones"}, {30'd0, a_done, b_done}, 32'd0);
    step;
    chk({tag, " done a_done"}, {31'd0, a_done}, {31'd0, sel_a});
    chk({tag, " done b_done"}, {31'd0, b_done}, {31'd0, ~sel_a});
    chk({tag, " done gnt"}, {30'd0, a_gnt, b_gnt}, sel_a ? 32'd2 : 32'd1);
    chk({tag, " done busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " result"}, result, exp);
    a_req = 0;
    b_req = 0;
    step;
    chk({tag, " idle outs"}, {27'd0, a_gnt, b_gnt, a_done, b_done, busy}, 32'd0);
    chk({tag, " result held"}, result, exp);
  endtask
  initial begin
    rst_n = 0; a_req = 0; b_req = 0;
    a_data = 0; a_len = 0; a_op = SHTOp_NOP;
    b_data = 0; b_len = 0; b_op = SHTOp_NOP;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {27'd0, a_gnt, b_gnt, a_done, b_done, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1;
    step;
    run_one("t1 sll", 1'b1, 32'h0000_00F0, 5'd4, SHTOp_SLL, 32'h0000_0F00);
    run_one("t2 sra", 1'b0, 32'h8000_0000, 5'd31, SHTOp_SRA, 32'hFFFF_FFFF);
    run_one("t2 srl", 1'b0, 32'h8000_0000, 5'd31, SHTOp_SRL, 32'h0000_0001);
    // both held: last winner was B, so A, B, A, B
    a_req = 1; a_data = 32'h0000_0001; a_len = 5'd3; a_op = SHTOp_SLL;
    b_req = 1; b_data = 32'h0000_0100; b_len = 5'd4; b_op = SHTOp_SRL;
    for (int g = 0; g < 4; g++) begin
      bit ia;
      ia = (g % 2 == 0);
      step;
      chk("t3 gnt", {30'd0, a_gnt, b_gnt}, ia ? 32'd2 : 32'd1);
      chk("t3 no done", {30'd0, a_done, b_done}, 32'd0);
      step;
      chk("t3 done", {30'd0, a_done, b_done}, ia ? 32'd2 : 32'd1);
      chk("t3 result", result, ia ? 32'h0000_0008 : 32'h0000_0010);
      if (g == 3) begin a_req = 0; b_req = 0; end
      step;
      chk("t3 idle", {27'd0, a_gnt, b_gnt, a_done, b_done, busy}, 32'd0);
    end
    // drop req and change operand during SHIFT
    a_req = 1; a_data = 32'h0000_0001; a_len = 5'd31; a_op = SHTOp_SLL;
    step;
    chk("t4 gnt", {31'd0, a_gnt}, 32'd1);
    a_req = 0; a_data = 32'h0000_FFFF; a_len = 5'd0;
    step;
    chk("t4 done", {31'd0, a_done}, 32'd1);
    chk("t4 result", result, 32'h8000_0000);
    step;
    chk("t4 idle", {27'd0, a_gnt, b_gnt, a_done, b_done, busy}, 32'd0);
    // async reset during SHIFT
    a_req = 1; a_data = 32'h0000_0003; a_len = 5'd1; a_op = SHTOp_SRL;
    step;
    chk("t5 gnt", {31'd0, a_gnt}, 32'd1);
    rst_n = 0;
    #1;
    chk("t5 async outs", {27'd0, a_gnt, b_gnt, a_done, b_done, busy}, 32'd0);
    chk("t5 async result", result, 32'd0);
    a_req = 0;
    step;
    chk("t5 no done", {30'd0, a_done, b_done}, 32'd0);
    rst_n = 1;
    step;
    run_one("t5 after", 1'b1, 32'h0000_0003, 5'd1, SHTOp_SRL, 32'h0000_0001);
    run_one("t6 nop", 1'b1, 32'hDEAD_BEEF, 5'd17, SHTOp_NOP, 32'hDEAD_BEEF);
    run_one("t6 len0", 1'b1, 32'hDEAD_BEEF, 5'd0, SHTOp_SLL, 32'hDEAD_BEEF);
    run_one("t6 sra pos", 1'b0, 32'h7000_0000, 5'd4, SHTOp_SRA, 32'h0700_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
